// File: rtl/servant_mem_arbiter.sv
// ---------------------------------------------------------------------------
// servant_mem_arbiter
//
// Shares the single-port servant RAM between the CPU Wishbone port and the
// VPU direct memory port. Each cycle at most one requester owns the RAM. A
// waiting CPU request can be held off by at most VPU_BURST_MAX consecutive
// VPU beats. CPU wait cycles are counted in a saturating 16-bit counter.
//
// Parameters
//   AW             RAM word-address width
//   VPU_BURST_MAX  VPU beats allowed while a CPU request waits (1..15)
//
// Ports
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_cpu_*             CPU request: adr/dat/sel/we, cyc held until ack
//   o_cpu_rdt/o_cpu_ack CPU read data and one-cycle acknowledge
//   i_vpu_*             VPU beat request: adr/dat/sel/we held until gnt
//   o_vpu_gnt           combinational: VPU beat issued to RAM this cycle
//   o_vpu_rdt/rvalid    VPU read data, valid one cycle after a read grant
//   o_ram_*             RAM port: en/we/adr/dat/sel
//   i_ram_rdt           RAM read data, valid the cycle after a read
//   o_stall_cnt         saturating count of CPU wait cycles
// ---------------------------------------------------------------------------
module servant_mem_arbiter #(
    parameter int AW            = 11,
    parameter int VPU_BURST_MAX = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [AW-1:0] i_cpu_adr,
    input  logic [31:0]   i_cpu_dat,
    input  logic [3:0]    i_cpu_sel,
    input  logic          i_cpu_we,
    input  logic          i_cpu_cyc,
    output logic [31:0]   o_cpu_rdt,
    output logic          o_cpu_ack,
    input  logic          i_vpu_req,
    input  logic          i_vpu_we,
    input  logic [AW-1:0] i_vpu_adr,
    input  logic [31:0]   i_vpu_dat,
    input  logic [3:0]    i_vpu_sel,
    output logic          o_vpu_gnt,
    output logic [31:0]   o_vpu_rdt,
    output logic          o_vpu_rvalid,
    output logic          o_ram_en,
    output logic          o_ram_we,
    output logic [AW-1:0] o_ram_adr,
    output logic [31:0]   o_ram_dat,
    output logic [3:0]    o_ram_sel,
    input  logic [31:0]   i_ram_rdt,
    output logic [15:0]   o_stall_cnt
);

    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_CPU  = 2'b01,
        GNT_VPU  = 2'b10
    } gnt_e;

    localparam logic [3:0] BURST_MAX_C = 4'(VPU_BURST_MAX);

    // Saturating increment of the 4-bit VPU run counter.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        logic [3:0] r;
        if (v == 4'hF) begin
            r = v;
        end else begin
            r = v + 4'd1;
        end
        return r;
    endfunction

    // Saturating increment of the 16-bit stall counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        logic [15:0] r;
        if (v == 16'hFFFF) begin
            r = v;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

    logic        cpu_ack_r;
    logic        vpu_rvalid_r;
    logic [3:0]  run_cnt_r;
    logic [15:0] stall_cnt_r;

    logic        cpu_pend_s;
    logic        vpu_req_s;
    logic        burst_ok_s;
    gnt_e        gnt_s;

    // The CPU keeps cyc high during its ack cycle; that cycle is not a new
    // request. Requests are also masked while reset is asserted so the RAM
    // port and grant drop to zero immediately, without waiting for a clock.
    assign cpu_pend_s = i_rst_n & i_cpu_cyc & ~cpu_ack_r;
    assign vpu_req_s  = i_rst_n & i_vpu_req;
    assign burst_ok_s = (run_cnt_r < BURST_MAX_C);

    // Grant selection: a lone requester wins; under contention the VPU keeps
    // the port until its run of beats reaches VPU_BURST_MAX.
    always_comb begin
        gnt_s = GNT_NONE;
        case ({cpu_pend_s, vpu_req_s})
            2'b10: gnt_s = GNT_CPU;
            2'b01: gnt_s = GNT_VPU;
            2'b11: begin
                if (burst_ok_s) begin
                    gnt_s = GNT_VPU;
                end else begin
                    gnt_s = GNT_CPU;
                end
            end
            default: gnt_s = GNT_NONE;
        endcase
    end

    // RAM port mux: driven from the owner, all zero when idle.
    always_comb begin
        o_ram_en  = 1'b0;
        o_ram_we  = 1'b0;
        o_ram_adr = '0;
        o_ram_dat = 32'h0;
        o_ram_sel = 4'h0;
        case (gnt_s)
            GNT_CPU: begin
                o_ram_en  = 1'b1;
                o_ram_we  = i_cpu_we;
                o_ram_adr = i_cpu_adr;
                o_ram_dat = i_cpu_dat;
                o_ram_sel = i_cpu_sel;
            end
            GNT_VPU: begin
                o_ram_en  = 1'b1;
                o_ram_we  = i_vpu_we;
                o_ram_adr = i_vpu_adr;
                o_ram_dat = i_vpu_dat;
                o_ram_sel = i_vpu_sel;
            end
            default: begin
                o_ram_en  = 1'b0;
                o_ram_we  = 1'b0;
                o_ram_adr = '0;
                o_ram_dat = 32'h0;
                o_ram_sel = 4'h0;
            end
        endcase
    end

    assign o_vpu_gnt = (gnt_s == GNT_VPU);

    // Response flags: CPU ack (reads and writes) and VPU read-valid, both one
    // cycle after the grant. A beat in flight at reset is dropped.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cpu_ack_r    <= 1'b0;
            vpu_rvalid_r <= 1'b0;
        end else begin
            cpu_ack_r    <= (gnt_s == GNT_CPU);
            vpu_rvalid_r <= (gnt_s == GNT_VPU) & ~i_vpu_we;
        end
    end

    // VPU run length while the CPU waits; restarts once the CPU is served or
    // is no longer waiting.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            run_cnt_r <= 4'd0;
        end else if ((gnt_s == GNT_CPU) || !cpu_pend_s) begin
            run_cnt_r <= 4'd0;
        end else if (gnt_s == GNT_VPU) begin
            run_cnt_r <= sat_inc4(run_cnt_r);
        end else begin
            run_cnt_r <= run_cnt_r;
        end
    end

    // CPU stall counter: one per cycle the CPU waits without a grant; sticks
    // at all-ones rather than wrapping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_cnt_r <= 16'd0;
        end else if (cpu_pend_s && (gnt_s != GNT_CPU)) begin
            stall_cnt_r <= sat_inc16(stall_cnt_r);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign o_cpu_ack    = cpu_ack_r;
    assign o_cpu_rdt    = cpu_ack_r ? i_ram_rdt : 32'h0;
    assign o_vpu_rvalid = vpu_rvalid_r;
    assign o_vpu_rdt    = vpu_rvalid_r ? i_ram_rdt : 32'h0;
    assign o_stall_cnt  = stall_cnt_r;

endmodule

// File: tb/tb_servant_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_servant_mem_arbiter
//
// Directed bench for servant_mem_arbiter. The main instance (burst limit 4)
// sits in front of a behavioural RAM. A second instance with burst limit 15
// is held in permanent contention to drive the stall counter to saturation.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_servant_mem_arbiter;

    localparam int AW = 11;

    logic          clk;
    logic          rst_n;

    // main instance
    logic [AW-1:0] cpu_adr;
    logic [31:0]   cpu_dat;
    logic [3:0]    cpu_sel;
    logic          cpu_we;
    logic          cpu_cyc;
    logic [31:0]   cpu_rdt;
    logic          cpu_ack;
    logic          vpu_req;
    logic          vpu_we;
    logic [AW-1:0] vpu_adr;
    logic [31:0]   vpu_dat;
    logic [3:0]    vpu_sel;
    logic          vpu_gnt;
    logic [31:0]   vpu_rdt;
    logic          vpu_rvalid;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_adr;
    logic [31:0]   ram_dat;
    logic [3:0]    ram_sel;
    logic [31:0]   ram_rdt;
    logic [15:0]   stall_cnt;

    // saturation instance
    logic          s_cpu_cyc;
    logic          s_vpu_req;
    logic [31:0]   s_ram_rdt;
    logic [31:0]   s_cpu_rdt;
    logic          s_cpu_ack;
    logic          s_vpu_gnt;
    logic [31:0]   s_vpu_rdt;
    logic          s_vpu_rvalid;
    logic          s_ram_en;
    logic          s_ram_we;
    logic [AW-1:0] s_ram_adr;
    logic [31:0]   s_ram_dat;
    logic [3:0]    s_ram_sel;
    logic [15:0]   s_stall_cnt;

    logic [31:0]   mem [0:(1<<AW)-1];

    int            n_checks;
    int            n_errors;
    int            beats;

    servant_mem_arbiter #(.AW(AW), .VPU_BURST_MAX(4)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cpu_adr(cpu_adr), .i_cpu_dat(cpu_dat), .i_cpu_sel(cpu_sel),
        .i_cpu_we(cpu_we), .i_cpu_cyc(cpu_cyc),
        .o_cpu_rdt(cpu_rdt), .o_cpu_ack(cpu_ack),
        .i_vpu_req(vpu_req), .i_vpu_we(vpu_we), .i_vpu_adr(vpu_adr),
        .i_vpu_dat(vpu_dat), .i_vpu_sel(vpu_sel),
        .o_vpu_gnt(vpu_gnt), .o_vpu_rdt(vpu_rdt), .o_vpu_rvalid(vpu_rvalid),
        .o_ram_en(ram_en), .o_ram_we(ram_we), .o_ram_adr(ram_adr),
        .o_ram_dat(ram_dat), .o_ram_sel(ram_sel), .i_ram_rdt(ram_rdt),
        .o_stall_cnt(stall_cnt)
    );

    servant_mem_arbiter #(.AW(AW), .VPU_BURST_MAX(15)) u_sat (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cpu_adr(11'h001), .i_cpu_dat(32'h0), .i_cpu_sel(4'hF),
        .i_cpu_we(1'b0), .i_cpu_cyc(s_cpu_cyc),
        .o_cpu_rdt(s_cpu_rdt), .o_cpu_ack(s_cpu_ack),
        .i_vpu_req(s_vpu_req), .i_vpu_we(1'b0), .i_vpu_adr(11'h002),
        .i_vpu_dat(32'h0), .i_vpu_sel(4'hF),
        .o_vpu_gnt(s_vpu_gnt), .o_vpu_rdt(s_vpu_rdt), .o_vpu_rvalid(s_vpu_rvalid),
        .o_ram_en(s_ram_en), .o_ram_we(s_ram_we), .o_ram_adr(s_ram_adr),
        .o_ram_dat(s_ram_dat), .o_ram_sel(s_ram_sel), .i_ram_rdt(s_ram_rdt),
        .o_stall_cnt(s_stall_cnt)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural single-port RAM: byte-enabled write, one-cycle read.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_sel[b]) mem[ram_adr][8*b +: 8] <= ram_dat[8*b +: 8];
                end
            end else begin
                ram_rdt <= mem[ram_adr];
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic sample();
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        beats     = 0;
        rst_n     = 1'b0;
        cpu_adr   = '0; cpu_dat = 32'h0; cpu_sel = 4'h0; cpu_we = 1'b0; cpu_cyc = 1'b0;
        vpu_req   = 1'b0; vpu_we = 1'b0; vpu_adr = '0; vpu_dat = 32'h0; vpu_sel = 4'h0;
        s_cpu_cyc = 1'b0; s_vpu_req = 1'b0; s_ram_rdt = 32'h0; ram_rdt = 32'h0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
        mem[11'h010] = 32'hDEADBEEF;
        mem[11'h030] = 32'h12345678;
        for (int i = 0; i < 8; i++) mem[11'h100 + i] = 32'hC0DE0000 + 32'(i);

        // ---------------- initial reset ----------------
        sample();
        check_val("rst_ack", {31'h0, cpu_ack}, 32'h0);
        check_val("rst_stall", {16'h0, stall_cnt}, 32'h0);
        next_cycle(); next_cycle();
        rst_n = 1'b1;

        // ---------------- CPU alone ----------------
        next_cycle();
        cpu_cyc = 1'b1; cpu_adr = 11'h010; cpu_we = 1'b0; cpu_sel = 4'hF;
        sample();
        check_val("cpu_ram_en", {31'h0, ram_en}, 32'h1);
        check_val("cpu_ram_adr", {21'h0, ram_adr}, 32'h010);
        check_val("cpu_no_early_ack", {31'h0, cpu_ack}, 32'h0);
        next_cycle();
        sample();
        check_val("cpu_ack", {31'h0, cpu_ack}, 32'h1);
        check_val("cpu_rdt", cpu_rdt, 32'hDEADBEEF);
        check_val("cpu_ackcyc_no_ram", {31'h0, ram_en}, 32'h0);
        next_cycle();
        cpu_cyc = 1'b0;
        sample();
        check_val("cpu_ack_drop", {31'h0, cpu_ack}, 32'h0);
        check_val("cpu_no_stall", {16'h0, stall_cnt}, 32'h0);

        // ---------------- reset mid CPU read ----------------
        next_cycle();
        cpu_cyc = 1'b1; cpu_adr = 11'h010;
        sample();
        check_val("mid_ram_en", {31'h0, ram_en}, 32'h1);
        next_cycle();
        sample();
        check_val("mid_ack_before", {31'h0, cpu_ack}, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check_val("mid_rst_ack", {31'h0, cpu_ack}, 32'h0);
        check_val("mid_rst_rdt", cpu_rdt, 32'h0);
        check_val("mid_rst_ram_en", {31'h0, ram_en}, 32'h0);
        check_val("mid_rst_ram_adr", {21'h0, ram_adr}, 32'h0);
        next_cycle();
        rst_n = 1'b1; cpu_cyc = 1'b0;
        sample();
        check_val("post_rst_ack", {31'h0, cpu_ack}, 32'h0);
        next_cycle();
        sample();
        check_val("post_rst_ack2", {31'h0, cpu_ack}, 32'h0);
        check_val("post_rst_stall", {16'h0, stall_cnt}, 32'h0);

        // ---------------- VPU read stream ----------------
        for (int i = 0; i <= 8; i++) begin
            next_cycle();
            vpu_req = (i < 8); vpu_we = 1'b0; vpu_sel = 4'hF;
            vpu_adr = 11'h100 + 11'(i);
            sample();
            check_val($sformatf("vs_gnt%0d", i), {31'h0, vpu_gnt}, (i < 8) ? 32'h1 : 32'h0);
            check_val($sformatf("vs_rvalid%0d", i), {31'h0, vpu_rvalid}, (i > 0) ? 32'h1 : 32'h0);
            if (i > 0) check_val($sformatf("vs_rdt%0d", i), vpu_rdt, 32'hC0DE0000 + 32'(i - 1));
            if (i < 8) check_val($sformatf("vs_adr%0d", i), {21'h0, ram_adr}, 32'h100 + 32'(i));
        end

        // ---------------- contention, burst limit 4 ----------------
        beats = 0;
        for (int c = 0; c <= 8; c++) begin
            next_cycle();
            vpu_req = 1'b1; vpu_we = 1'b0; vpu_adr = 11'h200 + 11'(beats);
            cpu_cyc = (c >= 2 && c <= 7); cpu_adr = 11'h030; cpu_we = 1'b0;
            sample();
            check_val($sformatf("ct_gnt%0d", c), {31'h0, vpu_gnt}, (c != 6) ? 32'h1 : 32'h0);
            check_val($sformatf("ct_ack%0d", c), {31'h0, cpu_ack}, (c == 7) ? 32'h1 : 32'h0);
            if (c == 6) check_val("ct_cpu_adr", {21'h0, ram_adr}, 32'h030);
            if (c == 7) begin
                check_val("ct_cpu_rdt", cpu_rdt, 32'h12345678);
                check_val("ct_no_rvalid_with_ack", {31'h0, vpu_rvalid}, 32'h0);
            end
            if (c == 8) check_val("ct_stall", {16'h0, stall_cnt}, 32'h4);
            if (vpu_gnt) beats++;
        end
        next_cycle();
        vpu_req = 1'b0; cpu_cyc = 1'b0;

        // ---------------- ordering: VPU write then CPU read ----------------
        next_cycle();
        vpu_req = 1'b1; vpu_we = 1'b1; vpu_adr = 11'h020; vpu_dat = 32'hA5A5A5A5; vpu_sel = 4'hF;
        sample();
        check_val("ord_vgnt", {31'h0, vpu_gnt}, 32'h1);
        check_val("ord_ram_we", {31'h0, ram_we}, 32'h1);
        next_cycle();
        vpu_req = 1'b0; vpu_we = 1'b0;
        cpu_cyc = 1'b1; cpu_adr = 11'h020; cpu_we = 1'b0;
        sample();
        check_val("ord_cpu_adr", {21'h0, ram_adr}, 32'h020);
        check_val("ord_no_rvalid_wr", {31'h0, vpu_rvalid}, 32'h0);
        next_cycle();
        sample();
        check_val("ord_ack", {31'h0, cpu_ack}, 32'h1);
        check_val("ord_rdt", cpu_rdt, 32'hA5A5A5A5);
        next_cycle();
        cpu_cyc = 1'b0;

        // ---------------- CPU byte write, VPU granted in ack cycle ----------------
        next_cycle();
        cpu_cyc = 1'b1; cpu_we = 1'b1; cpu_adr = 11'h020; cpu_dat = 32'hFFFFFFFF; cpu_sel = 4'b0011;
        sample();
        check_val("bw_sel", {28'h0, ram_sel}, 32'h3);
        check_val("bw_we", {31'h0, ram_we}, 32'h1);
        next_cycle();
        vpu_req = 1'b1; vpu_we = 1'b0; vpu_adr = 11'h020;
        sample();
        check_val("bw_ack", {31'h0, cpu_ack}, 32'h1);
        check_val("bw_vgnt_in_ack", {31'h0, vpu_gnt}, 32'h1);
        next_cycle();
        cpu_cyc = 1'b0; cpu_we = 1'b0; vpu_req = 1'b0;
        sample();
        check_val("bw_rvalid", {31'h0, vpu_rvalid}, 32'h1);
        check_val("bw_rdt", vpu_rdt, 32'hA5A5FFFF);
        check_val("bw_ack_drop", {31'h0, cpu_ack}, 32'h0);

        // ---------------- stall counter saturation, burst limit 15 ----------------
        next_cycle();
        s_cpu_cyc = 1'b1; s_vpu_req = 1'b1;
        repeat (170) @(negedge clk);
        sample();
        check_val("sat_partial", {16'h0, s_stall_cnt}, 32'd150);
        repeat (79500) @(negedge clk);
        sample();
        check_val("sat_full", {16'h0, s_stall_cnt}, 32'h0000FFFF);
        s_cpu_cyc = 1'b0; s_vpu_req = 1'b0;
        check_val("sat_main_untouched", {16'h0, stall_cnt}, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/servant_mem_arbiter.md
# servant_mem_arbiter

Single-port arbiter placed between the servant RAM and its two masters: the CPU Wishbone port (ibus/dbus already merged) and the VPU direct memory port. Each cycle it grants the RAM to at most one requester, returns read data and acknowledges to the owner, and bounds VPU bursts so the CPU is never starved. It also keeps a saturating count of CPU stall cycles for performance bring-up.

## Interface
Parameters:
- AW, 11, RAM word-address width (memsize/4).
- VPU_BURST_MAX, 4, max consecutive VPU beats granted while a CPU request waits (legal 1..15).

Ports:
- i_clk  in  1  system clock; all state on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_cpu_adr  in  AW  CPU word address.
- i_cpu_dat  in  32  CPU write data.
- i_cpu_sel  in  4  CPU byte enables.
- i_cpu_we  in  1  CPU write.
- i_cpu_cyc  in  1  CPU request; held until o_cpu_ack.
- o_cpu_rdt  out  32  CPU read data, valid with o_cpu_ack.
- o_cpu_ack  out  1  one-cycle CPU acknowledge.
- i_vpu_req  in  1  VPU beat request; adr/dat/sel/we held until o_vpu_gnt.
- i_vpu_we  in  1  VPU write.
- i_vpu_adr  in  AW  VPU word address.
- i_vpu_dat  in  32  VPU write data.
- i_vpu_sel  in  4  VPU byte enables.
- o_vpu_gnt  out  1  combinational: VPU beat issued to RAM this cycle.
- o_vpu_rdt  out  32  VPU read data, valid with o_vpu_rvalid.
- o_vpu_rvalid  out  1  one cycle after a granted VPU read.
- o_ram_en  out  1  RAM access this cycle.
- o_ram_we  out  1  RAM write.
- o_ram_adr  out  AW  RAM address.
- o_ram_dat  out  32  RAM write data.
- o_ram_sel  out  4  RAM byte enables.
- i_ram_rdt  in  32  RAM read data, valid cycle after a read en.
- o_stall_cnt  out  16  saturating count of CPU wait cycles.

## Operation
- Registered state: cpu_ack_q, vpu_rvalid_q, run_cnt[3:0], stall_cnt[15:0].
- cpu_pend = i_cpu_cyc & ~cpu_ack_q (CPU cyc is still high in its ack cycle and must be ignored there).
- Grant rule per cycle, evaluated combinationally:
  - cpu_pend & ~i_vpu_req -> CPU.
  - i_vpu_req & ~cpu_pend -> VPU.
  - both: VPU if run_cnt < VPU_BURST_MAX, else CPU.
  - neither -> no grant, o_ram_en=0, o_ram_adr/dat/sel/we driven 0.
- RAM mux: o_ram_* from granted side, o_ram_en=1.
- CPU grant: cpu_ack_q <= 1 next cycle; o_cpu_ack=cpu_ack_q; o_cpu_rdt=i_ram_rdt when cpu_ack_q, else 0. Writes also acknowledged after 1 cycle.
- VPU grant: o_vpu_gnt=1; if ~i_vpu_we, vpu_rvalid_q <= 1; o_vpu_rdt=i_ram_rdt when vpu_rvalid_q, else 0.
- run_cnt: cleared on CPU grant or whenever ~cpu_pend; incremented (saturating at 15) on VPU grant while cpu_pend.
- stall_cnt: +1 each cycle cpu_pend & no CPU grant; saturates at 16'hFFFF; never wraps.
- Ordering: accesses take effect in grant order; a VPU write granted the cycle before a CPU read of the same address is visible to that read.
- VPU may be granted during the CPU ack cycle (RAM port is free then).

## Timing
- Reset (async, i_rst_n low): cpu_ack_q, vpu_rvalid_q, run_cnt, stall_cnt = 0; all outputs 0 immediately; in-flight beat is discarded, no ack/rvalid after release.
- CPU latency: cyc seen in cycle N with grant -> o_cpu_ack in N+1; worst case with VPU saturating: ack in N+VPU_BURST_MAX+1.
- VPU throughput: one beat per cycle when CPU idle; read data exactly 1 cycle after gnt, in order.
- o_cpu_ack and o_vpu_rvalid never high in the same cycle.
- o_vpu_gnt is combinational from i_vpu_req/i_cpu_cyc and registered state; no other output combinationally depends on i_vpu_req except o_ram_*.

## Test plan
- Reset: drive i_rst_n=0 mid CPU read -> all outputs 0 at once; after release no o_cpu_ack; o_stall_cnt=0.
- CPU alone: read adr 0x010 holding 0xDEADBEEF -> o_ram_en cycle N, o_cpu_ack + o_cpu_rdt=0xDEADBEEF in N+1, cyc ignored during ack cycle (no second RAM access).
- VPU stream: 8 back-to-back reads adr 0x100..0x107 -> o_vpu_gnt 8 consecutive cycles, o_vpu_rvalid 8 cycles offset by 1, data in address order.
- Contention, VPU_BURST_MAX=4: VPU req continuous, CPU cyc asserted in cycle 2 -> VPU granted 4 beats, CPU granted cycle 6, ack cycle 7, VPU granted cycle 7 again; o_stall_cnt=4.
- Ordering: VPU write 0xA5A5A5A5 to 0x020 granted cycle N, CPU read 0x020 granted N+1 -> o_cpu_rdt=0xA5A5A5A5.
- Saturation: force 70000 CPU stall cycles with VPU_BURST_MAX=15 pattern -> o_stall_cnt holds 16'hFFFF, no wrap.
